line_arbiter: RTL and testbench

Two-port arbiter that shares the single cacheline adaptor / physical-memory port between the instruction cache and the data cache. Each cache presents the standard 256-bit line interface (address, read, write, wdata, rdata, resp). The arbiter grants one requester at a time, forwards its transaction downstream, routes the response back, and alternates priority between the two caches when both are pending. It sits between the two cache instances and the cacheline adaptor in the memory hierarchy.

---
 rtl/line_arbiter.sv | 61 ++++++
 tb/tb_line_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/line_arbiter.sv
// line_arbiter: shares one cacheline adaptor port between icache and dcache with alternating priority
module line_arbiter #(
  parameter int s_addr = 32,
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_line-1:0] i_pmem_wdata,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [s_addr-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  typedef enum logic [1:0] {idle, serve_i, serve_d} state_t;
  state_t state, state_n;
  logic prio, prio_n, i_req, d_req, sel_i, sel_d;
  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;
  assign sel_i = state == serve_i;
  assign sel_d = state == serve_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= idle;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
    end
  end
  always_comb begin
    state_n = state;
    prio_n  = prio;
    if (state == idle)
      state_n = (i_req && (!d_req || prio)) ? serve_i : d_req ? serve_d : idle;
    else if (pmem_resp) begin
      state_n = idle;
      prio_n  = sel_d;
    end
  end
  assign pmem_address = sel_i ? i_pmem_address : sel_d ? d_pmem_address : '0;
  assign pmem_wdata   = sel_i ? i_pmem_wdata : sel_d ? d_pmem_wdata : '0;
  assign pmem_write   = (sel_i & i_pmem_write) | (sel_d & d_pmem_write);
  assign pmem_read    = (sel_i & i_pmem_read & ~i_pmem_write) | (sel_d & d_pmem_read & ~d_pmem_write);
  assign i_pmem_resp  = sel_i & pmem_resp;
  assign d_pmem_resp  = sel_d & pmem_resp;
  assign i_pmem_rdata = sel_i ? pmem_rdata : '0;
  assign d_pmem_rdata = sel_d ? pmem_rdata : '0;
endmodule

// File: tb/tb_line_arbiter.sv
// tb_line_arbiter: directed self-checking bench for line_arbiter
module tb_line_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] i_pmem_address = 0, d_pmem_address = 0, pmem_address;
  logic i_pmem_read = 0, i_pmem_write = 0, d_pmem_read = 0, d_pmem_write = 0;
  logic [255:0] i_pmem_wdata = 0, d_pmem_wdata = 0, pmem_wdata, pmem_rdata = 0;
  logic [255:0] i_pmem_rdata, d_pmem_rdata;
  logic i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp = 0;
  int errors = 0, checks = 0;
  logic [255:0] pat_a5, pat_db;
  line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_wdata(i_pmem_wdata), .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, " rd"}, {255'd0, pmem_read}, 256'd0);
    chk({tag, " wr"}, {255'd0, pmem_write}, 256'd0);
    chk({tag, " addr"}, {224'd0, pmem_address}, 256'd0);
    chk({tag, " wdata"}, pmem_wdata, 256'd0);
    chk({tag, " resps"}, {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    chk({tag, " rdatas"}, i_pmem_rdata | d_pmem_rdata, 256'd0);
  endtask
  task automatic respond(input logic [255:0] data, input logic exp_i, input string tag);
    pmem_rdata = data;
    pmem_resp = 1;
    #1;
    chk({tag, " resp"}, {254'd0, i_pmem_resp, d_pmem_resp}, {254'd0, exp_i, ~exp_i});
    chk({tag, " rdata"}, exp_i ? i_pmem_rdata : d_pmem_rdata, data);
    chk({tag, " other rdata"}, exp_i ? d_pmem_rdata : i_pmem_rdata, 256'd0);
    tick();
    pmem_resp = 0;
    pmem_rdata = 0;
  endtask
  initial begin
    pat_a5 = {32{8'hA5}};
    pat_db = {8{32'hDEADBEEF}};
    tick(); tick();
    idle_outputs("reset");
    rst = 0;
    tick();
    i_pmem_address = 32'h40; i_pmem_read = 1;
    #1;
    chk("moore no early grant", {255'd0, pmem_read}, 256'd0);
    tick();
    chk("i read strobe", {254'd0, pmem_read, pmem_write}, 256'd2);
    chk("i read addr", {224'd0, pmem_address}, 256'h40);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("i hold", {255'd0, pmem_read}, 256'd1);
      chk("i no dresp", {255'd0, d_pmem_resp}, 256'd0);
    end
    respond(pat_a5, 1'b1, "i read");
    i_pmem_read = 0;
    #1;
    idle_outputs("after i read");
    d_pmem_address = 32'h100; d_pmem_wdata = pat_db; d_pmem_write = 1;
    tick();
    chk("d write strobe", {254'd0, pmem_read, pmem_write}, 256'd1);
    chk("d write addr", {224'd0, pmem_address}, 256'h100);
    chk("d write data", pmem_wdata, pat_db);
    tick();
    chk("d write hold", {255'd0, pmem_write}, 256'd1);
    respond(256'd0, 1'b0, "d write");
    d_pmem_write = 0;
    #1;
    idle_outputs("after d write");
    rst = 1;
    tick();
    rst = 0;
    i_pmem_read = 1; d_pmem_read = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt grant", {224'd0, pmem_address}, k[0] ? 256'h40 : 256'h100);
      chk("alt strobe", {255'd0, pmem_read}, 256'd1);
      respond(256'(k + 1), k[0], "alt");
      chk("alt bubble", {255'd0, pmem_read}, 256'd0);
    end
    i_pmem_read = 0; d_pmem_write = 1;
    tick();
    chk("rw as write", {254'd0, pmem_read, pmem_write}, 256'd1);
    respond(256'd0, 1'b0, "rw");
    d_pmem_read = 0; d_pmem_write = 0;
    pmem_resp = 1;
    #1;
    chk("stray resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    tick();
    pmem_resp = 0;
    i_pmem_read = 1;
    tick();
    chk("pre-reset grant", {255'd0, pmem_read}, 256'd1);
    rst = 1; i_pmem_read = 0;
    tick();
    rst = 0;
    idle_outputs("mid reset");
    pmem_resp = 1;
    #1;
    chk("post reset resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    tick();
    pmem_resp = 0;
    i_pmem_read = 1;
    tick();
    chk("wd grant i", {224'd0, pmem_address}, 256'h40);
    i_pmem_read = 0; d_pmem_read = 1;
    #1;
    chk("wd strobe falls", {255'd0, pmem_read}, 256'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wd hold i", {224'd0, pmem_address}, 256'h40);
    end
    respond(pat_a5, 1'b1, "wd");
    idle_outputs("wd idle");
    tick();
    chk("wd then d", {224'd0, pmem_address}, 256'h100);
    chk("wd then d rd", {255'd0, pmem_read}, 256'd1);
    respond(pat_db, 1'b0, "wd d");
    d_pmem_read = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
